// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and helpers for the SDRAM port arbiter
// Contents:
//   arb_state_t : arbiter FSM states (idle / issue to controller / await response)
//   wrap_next   : next port index, wrapping to 0 after n-1 by explicit compare
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  // Port counts need not be powers of two, so the wrap is an explicit compare.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// rtl/sdram_rr_picker.sv - combinational round-robin picker
// Ports:
//   pending : one bit per requester, set when that requester wants service
//   ptr     : index with the highest priority this round
//   valid   : at least one pending bit is set
//   idx     : first pending index at or after ptr, wrapping modulo N
module sdram_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest pending port
  // (smallest offset from ptr) is the last assignment and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (pending[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin sharing of one SDRAM controller command port
// Optional build macro: SDRAM_ARB_PORT0_PRIO_EN (port 0 strict priority, others round-robin)
// Ports:
//   clk, rst                            : clock, synchronous active-high reset
//   p_rd, p_wr, p_addr, p_wdata         : per-port requests (packed, port i at slice i)
//   p_ack                               : pulse when a port's request is captured
//   p_rvalid, p_wvalid, p_rdata         : per-port completion pulses, broadcast read data
//   c_rd, c_wr, c_addr, c_wdata         : request to the controller
//   c_rdy, c_rvalid, c_wvalid, c_rdata  : controller accept / response
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_LEN   = DATA_WIDTH / 8,
  parameter int PIDX_W     = $clog2(N_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             p_rd,
  input  logic [N_PORTS*WORD_LEN-1:0]    p_wr,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  p_wdata,
  output logic [N_PORTS-1:0]             p_ack,
  output logic [N_PORTS-1:0]             p_rvalid,
  output logic [N_PORTS-1:0]             p_wvalid,
  output logic [DATA_WIDTH-1:0]          p_rdata,
  output logic                           c_rd,
  output logic [WORD_LEN-1:0]            c_wr,
  output logic [ADDR_WIDTH-1:0]          c_addr,
  output logic [DATA_WIDTH-1:0]          c_wdata,
  input  logic                           c_rdy,
  input  logic                           c_rvalid,
  input  logic                           c_wvalid,
  input  logic [DATA_WIDTH-1:0]          c_rdata
);

  arb_state_t              state;
  logic [PIDX_W-1:0]       ptr;
  logic [PIDX_W-1:0]       winner;
  logic                    cap_rd;
  logic [WORD_LEN-1:0]     cap_wr;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata;

  logic [N_PORTS-1:0]      pending;
  logic [N_PORTS-1:0]      rr_pending;
  logic                    rr_valid;
  logic [PIDX_W-1:0]       rr_idx;
  logic                    grant_valid;
  logic [PIDX_W-1:0]       grant_idx;

  logic                    sel_rd;
  logic [WORD_LEN-1:0]     sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      pending[i] = p_rd[i] | (|p_wr[i*WORD_LEN +: WORD_LEN]);
    end
  end

`ifdef SDRAM_ARB_PORT0_PRIO_EN
  // Port 0 is taken out of the rotation and wins outright whenever it asks.
  assign rr_pending  = pending & ~N_PORTS'(1);
  assign grant_valid = pending[0] | rr_valid;
  assign grant_idx   = pending[0] ? '0 : rr_idx;
`else
  assign rr_pending  = pending;
  assign grant_valid = rr_valid;
  assign grant_idx   = rr_idx;
`endif

  sdram_rr_picker #(
    .N     (N_PORTS),
    .IDX_W (PIDX_W)
  ) u_picker (
    .pending (rr_pending),
    .ptr     (ptr),
    .valid   (rr_valid),
    .idx     (rr_idx)
  );

  // Mux the granted port's request fields for capture.
  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_idx == PIDX_W'(i)) begin
        sel_rd    = p_rd[i];
        sel_wr    = p_wr[i*WORD_LEN +: WORD_LEN];
        sel_addr  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      winner    <= '0;
      cap_rd    <= 1'b0;
      cap_wr    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            winner    <= grant_idx;
            cap_rd    <= sel_rd;
            // A simultaneous read and write is treated as a read.
            cap_wr    <= sel_rd ? '0 : sel_wr;
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (c_rdy) begin
            state <= ARB_BUSY;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
            if (winner != '0) ptr <= PIDX_W'(wrap_next(int'(winner), N_PORTS));
`else
            ptr <= PIDX_W'(wrap_next(int'(winner), N_PORTS));
`endif
          end
        end
        ARB_BUSY: begin
          if (c_rvalid || c_wvalid) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while rst is high so a reset cycle never leaks a
  // grant or response computed from pre-reset state.
  always_comb begin
    c_rd     = 1'b0;
    c_wr     = '0;
    c_addr   = '0;
    c_wdata  = '0;
    p_ack    = '0;
    p_rvalid = '0;
    p_wvalid = '0;
    p_rdata  = '0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) p_ack[grant_idx] = 1'b1;
        end
        ARB_ISSUE: begin
          c_rd    = cap_rd;
          c_wr    = cap_wr;
          c_addr  = cap_addr;
          c_wdata = cap_wdata;
        end
        ARB_BUSY: begin
          if (c_rvalid) begin
            p_rvalid[winner] = 1'b1;
            p_rdata          = c_rdata;
          end else if (c_wvalid) begin
            p_wvalid[winner] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  p_rd;
  logic [7:0]  p_wr;
  logic [99:0] p_addr;
  logic [63:0] p_wdata;
  logic [3:0]  p_ack, p_rvalid, p_wvalid;
  logic [15:0] p_rdata;
  logic        c_rd;
  logic [1:0]  c_wr;
  logic [24:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_rdy, c_rvalid, c_wvalid;
  logic [15:0] c_rdata;

  sdram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(p_ack), .p_rvalid(p_rvalid), .p_wvalid(p_wvalid), .p_rdata(p_rdata),
    .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdy(c_rdy), .c_rvalid(c_rvalid), .c_wvalid(c_wvalid), .c_rdata(c_rdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic        rd;
    logic [1:0]  wr;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  wv;
    logic [15:0] data;
  } resp_t;

  acc_t  acc_q[$];
  resp_t resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int acc_seen = 0;
  bit done     = 0;
  bit ctl_auto = 1;
  int stale_cnt = 0;

  logic        r_rd[4];
  logic [1:0]  r_wr[4];
  logic [24:0] r_addr[4];
  logic [15:0] r_wdata[4];
  int          tgt[4];
  int          start_cnt[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [24:0] a);
    return a[15:0] + 16'hBDCC;
  endfunction

  task automatic set_req(input int port, input logic rd, input logic [1:0] wr,
                         input logic [24:0] addr, input logic [15:0] wdata);
    r_rd[port]    = rd;
    r_wr[port]    = wr;
    r_addr[port]  = addr;
    r_wdata[port] = wdata;
  endtask

  task automatic expect_txn(input int port, input bit with_resp);
    acc_t  a;
    resp_t r;
    a.addr  = r_addr[port];
    a.rd    = r_rd[port];
    a.wr    = r_rd[port] ? 2'b00 : r_wr[port];
    a.wdata = r_wdata[port];
    acc_q.push_back(a);
    if (with_resp) begin
      r.rv   = r_rd[port] ? (4'b0001 << port) : 4'b0000;
      r.wv   = r_rd[port] ? 4'b0000 : (4'b0001 << port);
      r.data = r_rd[port] ? model_data(r_addr[port]) : 16'h0000;
      resp_q.push_back(r);
    end
  endtask

  task automatic drain(input string tag, input int limit);
    for (int k = 0; k < limit && (acc_q.size() != 0 || resp_q.size() != 0); k++) @(negedge clk);
    check({"drain_", tag}, 64'(acc_q.size() + resp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; c_rdy = 1'b1;
    c_rvalid = 1'b0; c_wvalid = 1'b0; c_rdata = '0;
    p_rd = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b0, 2'b00, '0, '0);
      tgt[i] = 0;
      start_cnt[i] = 0;
    end

    fork
      // ---------------- main stimulus ----------------
      begin : main_seq
        int order[8];
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_c", {c_rd, c_wr, c_addr, c_wdata}, 64'd0);
        check("reset_p", {p_ack, p_rvalid, p_wvalid, p_rdata}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Rotation: all four ports pending, each reissues once.
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        order = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          set_req(i, 1'b1, 2'b00, 25'(i * 'h10000 + 'h40), 16'h0000);
          tgt[i] = tgt[i] + 1;
        end
        for (int j = 0; j < 8; j++) expect_txn(order[j], 1'b1);
        for (int i = 0; i < 4; i++) start_cnt[i] = start_cnt[i] + 1;
        drain("rotation", 400);

        // Single read on port 2 with latency checks.
        @(negedge clk);
        set_req(2, 1'b1, 2'b00, 25'h000123, 16'h0000);
        expect_txn(2, 1'b1);
        start_cnt[2] = start_cnt[2] + 1;
        @(negedge clk);
        check("t1_ack", p_ack, 4'b0100);
        check("t1_crd_T", c_rd, 1'b0);
        @(negedge clk);
        check("t1_crd_T1", c_rd, 1'b1);
        check("t1_caddr", c_addr, 25'h000123);
        check("t1_ack_T1", p_ack, 4'b0000);
        drain("single", 50);

        // Write on port 1 held off by c_rdy low for 20 cycles.
        @(posedge clk); #1 c_rdy = 1'b0;
        @(negedge clk);
        set_req(1, 1'b0, 2'b01, 25'h0002A0, 16'h00A5);
        expect_txn(1, 1'b1);
        start_cnt[1] = start_cnt[1] + 1;
        @(negedge clk);
        check("wr_ack", p_ack, 4'b0010);
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("hold_c_wr", c_wr, 2'b01);
          check("hold_c_wdata", c_wdata, 16'h00A5);
        end
        @(posedge clk); #1 c_rdy = 1'b1;
        drain("write", 50);

        // Read and write strobes together on port 3: read wins.
        @(negedge clk);
        set_req(3, 1'b1, 2'b11, 25'h0ABCDE, 16'h1234);
        expect_txn(3, 1'b1);
        start_cnt[3] = start_cnt[3] + 1;
        drain("conflict", 50);

        // Reset while BUSY, then a stale controller response.
        @(posedge clk); #1 ctl_auto = 1'b0;
        @(negedge clk);
        set_req(1, 1'b1, 2'b00, 25'h000777, 16'h0000);
        expect_txn(1, 1'b0);
        start_cnt[1] = start_cnt[1] + 1;
        base = acc_seen;
        for (int k = 0; k < 50 && acc_seen == base; k++) @(negedge clk);
        check("rst_accepted", 64'(acc_seen - base), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_busy_c", {c_rd, c_wr, c_addr, c_wdata}, 64'd0);
        check("rst_busy_p", {p_ack, p_rvalid, p_wvalid, p_rdata}, 64'd0);
        @(posedge clk); #1 rst = 1'b0; stale_cnt = stale_cnt + 1;
        @(negedge clk);
        @(negedge clk);
        check("stale_rvalid", p_rvalid, 4'b0000);
        check("stale_rdata", p_rdata, 16'h0000);
        @(posedge clk); #1 ctl_auto = 1'b1;
        @(negedge clk);
        set_req(3, 1'b1, 2'b00, 25'h030333, 16'h0000);
        set_req(0, 1'b1, 2'b00, 25'h000999, 16'h0000);
        expect_txn(0, 1'b1);
        expect_txn(3, 1'b1);
        start_cnt[0] = start_cnt[0] + 1;
        start_cnt[3] = start_cnt[3] + 1;
        drain("post_reset", 100);

`ifdef SDRAM_ARB_PORT0_PRIO_EN
        // Port 0 keeps requesting; port 2 waits until port 0 stops.
        @(negedge clk);
        set_req(0, 1'b1, 2'b00, 25'h000400, 16'h0000);
        set_req(2, 1'b1, 2'b00, 25'h020400, 16'h0000);
        tgt[0] = tgt[0] + 2;
        for (int j = 0; j < 3; j++) expect_txn(0, 1'b1);
        expect_txn(2, 1'b1);
        start_cnt[0] = start_cnt[0] + 1;
        start_cnt[2] = start_cnt[2] + 1;
        drain("prio", 200);
`endif
        done = 1'b1;
      end

      // ---------------- requester model ----------------
      begin : req_model
        logic [3:0] ack_s, done_s;
        int reissued[4];
        int seen_cnt[4];
        for (int i = 0; i < 4; i++) begin
          reissued[i] = 0;
          seen_cnt[i] = 0;
        end
        while (!done) begin
          @(negedge clk);
          ack_s  = p_ack;
          done_s = p_rvalid | p_wvalid;
          @(posedge clk); #1;
          for (int i = 0; i < 4; i++) begin
            if (ack_s[i]) begin
              p_rd[i] = 1'b0;
              p_wr[i*2 +: 2] = 2'b00;
            end
            if (start_cnt[i] != seen_cnt[i] || (done_s[i] && reissued[i] < tgt[i])) begin
              if (start_cnt[i] != seen_cnt[i]) seen_cnt[i] = start_cnt[i];
              else reissued[i] = reissued[i] + 1;
              p_rd[i] = r_rd[i];
              p_wr[i*2 +: 2] = r_wr[i];
              p_addr[i*25 +: 25] = r_addr[i];
              p_wdata[i*16 +: 16] = r_wdata[i];
            end
          end
        end
      end

      // ---------------- controller model ----------------
      begin : ctl_model
        logic        is_rd;
        logic [24:0] a;
        int          lat;
        int          stale_seen;
        stale_seen = 0;
        while (!done) begin
          @(negedge clk);
          if (!rst && ctl_auto && c_rdy && (c_rd || c_wr != 2'b00)) begin
            is_rd = c_rd;
            a     = c_addr;
            lat   = $urandom_range(0, 2);
            @(posedge clk);
            repeat (lat) @(posedge clk);
            #1;
            c_rvalid = is_rd;
            c_wvalid = !is_rd;
            c_rdata  = is_rd ? model_data(a) : 16'h0000;
            @(posedge clk); #1;
            c_rvalid = 1'b0; c_wvalid = 1'b0; c_rdata = '0;
          end else if (stale_cnt != stale_seen) begin
            stale_seen = stale_cnt;
            @(posedge clk); #1;
            c_rvalid = 1'b1; c_rdata = 16'h1234;
            @(posedge clk); #1;
            c_rvalid = 1'b0; c_rdata = '0;
          end
        end
      end

      // ---------------- monitor / scoreboard ----------------
      begin : monitor
        acc_t  ea;
        resp_t er;
        while (!done) begin
          @(negedge clk);
          if (!rst) begin
            check("ack_onehot", 64'($countones(p_ack) <= 1), 64'd1);
            if (c_rdy && (c_rd || c_wr != 2'b00)) begin
              acc_seen++;
              if (acc_q.size() == 0) begin
                check("acc_unexpected", 64'(acc_q.size()), 64'd1);
              end else begin
                ea = acc_q.pop_front();
                check("acc_addr", c_addr, ea.addr);
                check("acc_rd", c_rd, ea.rd);
                check("acc_wr", c_wr, ea.wr);
                check("acc_wdata", c_wdata, ea.wdata);
              end
            end
            if ((p_rvalid | p_wvalid) != 4'b0000) begin
              if (resp_q.size() == 0) begin
                check("resp_unexpected", 64'(resp_q.size()), 64'd1);
              end else begin
                er = resp_q.pop_front();
                check("resp_rvalid", p_rvalid, er.rv);
                check("resp_wvalid", p_wvalid, er.wv);
                check("resp_rdata", p_rdata, er.data);
              end
            end else begin
              check("rdata_idle", p_rdata, 16'h0000);
            end
          end
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port (rd / wr-strobe / addr / write_data, with rdy / rvalid / wvalid) among N_PORTS requesters, e.g. CPU fetch, CPU data, video scanout and DMA.
- Round-robin arbitration with at most one transaction outstanding to the controller.
- Each request is captured into local registers, presented to the controller, and its response is routed back to the originating port.
- Sits between the requester fabric and the SDRAM controller core; both use the same clk/rst.

Parameters:
- N_PORTS, 4, number of requester ports (2..8).
- ADDR_WIDTH, 25, byte address width; {row, bank, col, byte} packing is passed through untouched.
- DATA_WIDTH, 16, word width: 8, 16 or 32.
- WORD_LEN, DATA_WIDTH/8, write byte-strobe width.
- PIDX_W, $clog2(N_PORTS), port index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- p_rd  in  N_PORTS  per-port read request.
- p_wr  in  N_PORTS*WORD_LEN  per-port write byte strobes; nonzero means write request.
- p_addr  in  N_PORTS*ADDR_WIDTH  per-port byte address.
- p_wdata  in  N_PORTS*DATA_WIDTH  per-port write data.
- p_ack  out  N_PORTS  one-cycle pulse: the port's request was captured.
- p_rvalid  out  N_PORTS  one-cycle read-complete pulse.
- p_wvalid  out  N_PORTS  one-cycle write-complete pulse.
- p_rdata  out  DATA_WIDTH  read data, broadcast to all ports, qualified by p_rvalid.
- c_rd  out  1  controller read request.
- c_wr  out  WORD_LEN  controller write strobes.
- c_addr  out  ADDR_WIDTH  controller address.
- c_wdata  out  DATA_WIDTH  controller write data.
- c_rdy  in  1  controller ready; the controller accepts when c_rdy & (c_rd | c_wr!=0).
- c_rvalid  in  1  controller read-data-valid pulse.
- c_wvalid  in  1  controller write-done pulse.
- c_rdata  in  DATA_WIDTH  controller read data; zero when not valid.

Behaviour:
- Port i is pending when p_rd[i] | (p_wr[i]!=0). The requester holds addr/data/strobes stable until p_ack[i], and must not assert a new request until its rvalid/wvalid returns.
- If p_rd[i] and p_wr[i] are both set: read wins, captured strobes forced to 0.
- State IDLE:
  - If any port is pending, pick the winner: first pending port at or after ptr, wrapping modulo N_PORTS.
  - Same cycle: p_ack[winner]=1 (combinational); capture rd/wr/addr/wdata and winner index into registers; next state ISSUE.
- State ISSUE:
  - c_rd/c_wr/c_addr/c_wdata driven from the capture registers.
  - When c_rdy=1, the controller accepts: next state BUSY; ptr <= winner+1, wrapping to 0 after N_PORTS-1.
  - c_rd/c_wr drop to 0 in BUSY, so exactly one accept occurs.
- State BUSY:
  - c_* request lines are 0.
  - On c_rvalid: p_rvalid[winner]=1 same cycle (combinational), p_rdata=c_rdata, next state IDLE.
  - On c_wvalid: p_wvalid[winner]=1, next state IDLE.
  - c_rvalid/c_wvalid outside BUSY are ignored.
- p_rdata is 0 whenever no p_rvalid bit is set.
- Latency: request seen in cycle T → ack in T → c_rd in T+1 → accept when c_rdy → response passes through with 0 added cycles. Next arbitration happens in the cycle after the response.
- Fairness: with all ports permanently pending, grants rotate 0,1,2,3,0,… No port waits more than N_PORTS-1 transactions.
- c_rdy low (refresh, boot): the arbiter stays in ISSUE indefinitely with the request held; no timeout.
- Reset mid-operation:
  - State IDLE, ptr=0, capture registers cleared.
  - All outputs 0: c_rd=0, c_wr=0, c_addr=0, c_wdata=0, p_ack=0, p_rvalid=0, p_wvalid=0, p_rdata=0.
  - The in-flight transaction is abandoned; a stale controller response is dropped because state is not BUSY.
- Widths: ptr and winner are PIDX_W bits. Wrap is explicit compare-to-(N_PORTS-1), not a power-of-two overflow.

Optional Feature:
- Macro SDRAM_ARB_PORT0_PRIO_EN.
- Defined: port 0 is strict high priority. In IDLE, a pending port 0 always wins regardless of ptr. A grant to port 0 does not modify ptr. Ports 1..N_PORTS-1 round-robin among themselves.
- Undefined: pure round-robin across all ports as above.

Decomposition:
- Package sdram_arb_pkg: state enum {ARB_IDLE, ARB_ISSUE, ARB_BUSY}, and a function computing the wrapped next index.
- Sub-module sdram_rr_picker: purely combinational, pending[N] + ptr → valid + index. Instantiated once; it is reused by the port-0-priority variant for the lower ports.

Test Plan:
- Single read: port 2 reads addr 0x000123, controller returns 0xBEEF → p_ack[2] in cycle T, c_rd=1 with c_addr=0x000123 in T+1, p_rvalid[2]=1 with p_rdata=0xBEEF; no other port flags.
- Rotation: all 4 ports read continuously, ptr=0 → grant order 0,1,2,3,0,1; exactly one c_rd accept per transaction.
- Write held off: port 1 writes strobes 2'b01, data 0x00A5, while c_rdy=0 for 20 cycles → c_wr=2'b01 held for 20 cycles, one accept after c_rdy rises, then p_wvalid[1]=1.
- Read+write conflict: p_rd[3]=1 with p_wr[3]=2'b11 → c_rd=1, c_wr=0; response arrives on p_rvalid[3].
- Reset in BUSY: rst asserted after accept, then c_rvalid=1 one cycle after rst drops → no p_rvalid bit set; all outputs 0; next grant goes to port 0.
- With SDRAM_ARB_PORT0_PRIO_EN: ports 0 and 2 continuously pending → port 0 wins every arbitration; ptr unchanged. Port 0 drops → port 2 is granted.
